conv3x3_window_filter: RTL and testbench

- Downstream consumer of the 3x3 window memory stage.
- Takes the nine 8-bit window pixels each cycle they are valid and computes a programmable signed 3x3 weighted sum, then rounds, shifts and clamps it to 8 bits.
- Drives the result onto the write port (pixelw/wr) of the result memory.
- Tracks output column/row position and flags end of frame.

---
 rtl/conv3x3_window_filter.sv | 154 +++++++++++++++
 tb/tb_conv3x3_window_filter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_filter.sv
// rtl/conv3x3_window_filter.sv - programmable signed 3x3 weighted-sum filter with round/shift/clamp and position tracking
module conv3x3_window_filter #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 32,
    parameter int ACC_W = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] pixelr1,
    input  logic [7:0] pixelr2,
    input  logic [7:0] pixelr3,
    input  logic [7:0] pixelr4,
    input  logic [7:0] pixelr5,
    input  logic [7:0] pixelr6,
    input  logic [7:0] pixelr7,
    input  logic [7:0] pixelr8,
    input  logic [7:0] pixelr9,
    input  logic       cfg_wr,
    input  logic [3:0] cfg_idx,
    input  logic [7:0] cfg_data,
    output logic [7:0] pixelw,
    output logic       wr,
    output logic       clip,
    output logic       frame_done,
    output logic [8:0] out_col,
    output logic [5:0] out_row
);

    localparam logic [8:0] COL_LAST = 9'(IMG_W - 1);
    localparam logic [5:0] ROW_LAST = 6'(IMG_H - 1);

    logic        [7:0]       pix     [9];
    logic signed [7:0]       coef    [9];
    logic        [3:0]       shift_q;
    logic signed [16:0]      prod_c  [9];
    logic signed [16:0]      prod_q  [9];
    logic signed [ACC_W-1:0] row_q   [3];
    logic signed [ACC_W-1:0] acc_q;
    logic        [3:0]       sh1, sh2, sh3;
    logic                    v1, v2, v3;
    logic signed [ACC_W:0]   rnd_add, rnd, shd;
    logic        [7:0]       pix_c;
    logic                    clip_c;
    logic        [8:0]       col_cnt;
    logic        [5:0]       row_cnt;

    // Gather the window taps into an indexable array (index 4 is the centre)
    always_comb begin
        pix[0] = pixelr1;
        pix[1] = pixelr2;
        pix[2] = pixelr3;
        pix[3] = pixelr4;
        pix[4] = pixelr5;
        pix[5] = pixelr6;
        pix[6] = pixelr7;
        pix[7] = pixelr8;
        pix[8] = pixelr9;
    end

    // Coefficient and shift registers; reset leaves the filter as a passthrough
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) coef[i] <= (i == 4) ? 8'sd1 : 8'sd0;
            shift_q <= 4'd0;
        end else if (cfg_wr) begin
            for (int i = 0; i < 9; i++) begin
                if (cfg_idx == 4'(i)) coef[i] <= cfg_data;
            end
            if (cfg_idx == 4'd9) shift_q <= cfg_data[3:0];
        end
    end

    // Pixels are unsigned, so zero-extend before the signed multiply
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_c[i] = $signed({9'b0, pix[i]}) * $signed({{9{coef[i][7]}}, coef[i]});
        end
    end

    // Valid bits; clearing them on reset discards any in-flight windows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Datapath registers; the shift travels with each window so config changes never hit in-flight data
    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) prod_q[i] <= prod_c[i];
        sh1 <= shift_q;
        for (int r = 0; r < 3; r++) begin
            row_q[r] <= {{(ACC_W-17){prod_q[3*r][16]}},   prod_q[3*r]}
                      + {{(ACC_W-17){prod_q[3*r+1][16]}}, prod_q[3*r+1]}
                      + {{(ACC_W-17){prod_q[3*r+2][16]}}, prod_q[3*r+2]};
        end
        sh2   <= sh1;
        acc_q <= row_q[0] + row_q[1] + row_q[2];
        sh3   <= sh2;
    end

    // Round half-up, arithmetic shift, then saturate to the unsigned 8-bit range
    always_comb begin
        rnd_add = (sh3 == 4'd0) ? '0 : $signed((ACC_W+1)'(1) << (sh3 - 4'd1));
        rnd     = $signed({acc_q[ACC_W-1], acc_q}) + rnd_add;
        shd     = rnd >>> sh3;
        pix_c   = shd[7:0];
        clip_c  = 1'b0;
        if (shd[ACC_W]) begin
            pix_c  = 8'd0;
            clip_c = 1'b1;
        end else if (|shd[ACC_W-1:8]) begin
            pix_c  = 8'd255;
            clip_c = 1'b1;
        end
    end

    // Output register and position counters; counters advance only when a pixel is written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixelw     <= 8'd0;
            wr         <= 1'b0;
            clip       <= 1'b0;
            frame_done <= 1'b0;
            out_col    <= 9'd0;
            out_row    <= 6'd0;
            col_cnt    <= 9'd0;
            row_cnt    <= 6'd0;
        end else begin
            wr         <= v3;
            frame_done <= 1'b0;
            if (v3) begin
                pixelw     <= pix_c;
                clip       <= clip_c;
                out_col    <= col_cnt;
                out_row    <= row_cnt;
                frame_done <= (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
                if (col_cnt == COL_LAST) begin
                    col_cnt <= 9'd0;
                    row_cnt <= (row_cnt == ROW_LAST) ? 6'd0 : row_cnt + 6'd1;
                end else begin
                    col_cnt <= col_cnt + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_window_filter.sv
// tb/tb_conv3x3_window_filter.sv - directed self-checking bench for conv3x3_window_filter
module tb_conv3x3_window_filter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [8:0][7:0] win;
    logic            cfg_wr;
    logic [3:0]      cfg_idx;
    logic [7:0]      cfg_data;
    logic [7:0]      pixelw;
    logic            wr, clip, frame_done;
    logic [8:0]      out_col;
    logic [5:0]      out_row;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [8:0][7:0] k;
        logic [3:0]      sh;
        logic [8:0][7:0] px;
        logic [7:0]      ep;
        logic            ec;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    conv3x3_window_filter #(.IMG_W(256), .IMG_H(32), .ACC_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .pixelr1(win[0]), .pixelr2(win[1]), .pixelr3(win[2]),
        .pixelr4(win[3]), .pixelr5(win[4]), .pixelr6(win[5]),
        .pixelr7(win[6]), .pixelr8(win[7]), .pixelr9(win[8]),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .pixelw(pixelw), .wr(wr), .clip(clip), .frame_done(frame_done),
        .out_col(out_col), .out_row(out_row)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [7:0] data);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_data = data;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic run_window(input string name, input int ep, input int ec);
        @(negedge clk); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); check({name, " wr early"}, int'(wr), 0);
        @(negedge clk);
        check({name, " wr"}, int'(wr), 1);
        check({name, " pixelw"}, int'(pixelw), ep);
        check({name, " clip"}, int'(clip), ec);
    endtask

    initial begin
        int seen, cyc, errs, fd_cnt, fd_col, fd_row, nx_col, nx_row, i;

        vecs[0]  = '{k: {9{8'd1}}, sh: 4'd3, px: {9{8'd200}}, ep: 8'd225, ec: 1'b0};
        vecs[1]  = '{k: {{4{8'hFF}}, 8'd8, {4{8'hFF}}}, sh: 4'd0, px: {{4{8'd0}}, 8'd255, {4{8'd0}}}, ep: 8'd255, ec: 1'b1};
        vecs[2]  = '{k: {{4{8'hFF}}, 8'd8, {4{8'hFF}}}, sh: 4'd0, px: {{4{8'd255}}, 8'd0, {4{8'd255}}}, ep: 8'd0, ec: 1'b1};
        vecs[3]  = '{k: {{4{8'hFF}}, 8'd8, {4{8'hFF}}}, sh: 4'd0, px: {9{8'd90}}, ep: 8'd0, ec: 1'b0};
        vecs[4]  = '{k: {9{8'd1}}, sh: 4'd3, px: {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, ep: 8'd6, ec: 1'b0};
        vecs[5]  = '{k: {{4{8'd0}}, 8'd1, {4{8'd0}}}, sh: 4'd0, px: {9{8'd255}}, ep: 8'd255, ec: 1'b0};
        vecs[6]  = '{k: {9{8'h80}}, sh: 4'd0, px: {9{8'd255}}, ep: 8'd0, ec: 1'b1};
        vecs[7]  = '{k: {9{8'd127}}, sh: 4'd15, px: {9{8'd255}}, ep: 8'd9, ec: 1'b0};
        vecs[8]  = '{k: {{4{8'd0}}, 8'd1, {4{8'd0}}}, sh: 4'd1, px: {{4{8'd0}}, 8'd3, {4{8'd0}}}, ep: 8'd2, ec: 1'b0};
        vecs[9]  = '{k: {{4{8'd0}}, 8'hFF, {4{8'd0}}}, sh: 4'd1, px: {{4{8'd0}}, 8'd3, {4{8'd0}}}, ep: 8'd0, ec: 1'b1};
        vecs[10] = '{k: {{4{8'd0}}, 8'd2, {4{8'd0}}}, sh: 4'd2, px: {{4{8'd0}}, 8'd101, {4{8'd0}}}, ep: 8'd51, ec: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_data = '0; win = '0;
        repeat (3) @(negedge clk);
        check("reset wr", int'(wr), 0);
        check("reset pixelw", int'(pixelw), 0);
        check("reset clip", int'(clip), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset out_col", int'(out_col), 0);
        check("reset out_row", int'(out_row), 0);
        rst_n = 1'b1;

        // Passthrough defaults: three back-to-back windows with noisy neighbours
        @(negedge clk);
        for (int j = 0; j < 9; j++) win[j] = 8'($urandom);
        win[4] = 8'd10; in_valid = 1'b1;
        @(negedge clk); win[4] = 8'd20;
        @(negedge clk); win[4] = 8'd30;
        @(negedge clk); in_valid = 1'b0;
        check("stream wr early", int'(wr), 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("stream wr", int'(wr), 1);
            check("stream pixelw", int'(pixelw), 10 * (j + 1));
            check("stream clip", int'(clip), 0);
        end
        @(negedge clk); check("stream wr gap", int'(wr), 0);

        // Coefficient change in the same cycle as window A only affects window B
        win = '0;
        @(negedge clk);
        win[4] = 8'd50; in_valid = 1'b1;
        cfg_wr = 1'b1; cfg_idx = 4'd4; cfg_data = 8'd2;
        @(negedge clk); cfg_wr = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); check("race wr early", int'(wr), 0);
        @(negedge clk);
        check("race A wr", int'(wr), 1);
        check("race A pixelw", int'(pixelw), 50);
        @(negedge clk);
        check("race B wr", int'(wr), 1);
        check("race B pixelw", int'(pixelw), 100);

        for (int v = 0; v < 11; v++) begin
            for (int j = 0; j < 9; j++) cfg_write(4'(j), vecs[v].k[j]);
            cfg_write(4'd9, {4'd0, vecs[v].sh});
            win = vecs[v].px;
            run_window($sformatf("vec%0d", v), int'(vecs[v].ep), int'(vecs[v].ec));
        end

        // Full frame plus one window, random gaps in in_valid
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        win = '0;
        seen = 0; cyc = 0; errs = 0; fd_cnt = 0; fd_col = -1; fd_row = -1; nx_col = -1; nx_row = -1;
        fork
            begin
                i = 0;
                while (i < 8193) begin
                    @(negedge clk);
                    if ($urandom_range(0, 3) != 0) begin
                        in_valid = 1'b1; win[4] = 8'(i); i++;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk); in_valid = 1'b0;
            end
            begin
                while (seen < 8193 && cyc < 40000) begin
                    @(negedge clk); cyc++;
                    if (wr) begin
                        if (int'(out_col) != seen % 256 || int'(out_row) != (seen / 256) % 32) errs++;
                        if (int'(pixelw) != seen % 256) errs++;
                        if (int'(frame_done) != int'(seen == 8191)) errs++;
                        if (frame_done) begin
                            fd_cnt++; fd_col = int'(out_col); fd_row = int'(out_row);
                        end
                        if (seen == 8192) begin
                            nx_col = int'(out_col); nx_row = int'(out_row);
                        end
                        seen++;
                    end else if (frame_done) begin
                        fd_cnt++; errs++;
                    end
                end
            end
        join
        check("frame wr count", seen, 8193);
        check("frame per-pixel errors", errs, 0);
        check("frame_done count", fd_cnt, 1);
        check("frame_done col", fd_col, 255);
        check("frame_done row", fd_row, 31);
        check("next frame col", nx_col, 0);
        check("next frame row", nx_row, 0);

        // Reset with two box-blur windows in flight
        for (int j = 0; j < 9; j++) cfg_write(4'(j), 8'd1);
        cfg_write(4'd9, 8'd3);
        win = {9{8'd200}};
        @(negedge clk); in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("rst wr", int'(wr), 0);
        check("rst out_col", int'(out_col), 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); check("rst in-flight dropped", int'(wr), 0);
        end
        cfg_write(4'd13, 8'd5);
        win = {{4{8'd200}}, 8'd77, {4{8'd200}}};
        run_window("post-reset passthrough", 77, 0);
        check("post-reset out_col", int'(out_col), 0);
        check("post-reset out_row", int'(out_row), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
